// File: rtl/xlib_dma_pkg.sv
// xlib_dma_pkg: shared DMA constants (default data/level widths, tagged-word width)
package xlib_dma_pkg;
    localparam int DMA_DW = 32;
    localparam int DMA_FW = 6;
    localparam int DMA_TW = DMA_DW + 1;
    function automatic int tag_w(input int dw);
        return dw + 1;
    endfunction
endpackage

// File: rtl/xlib_ram_sdp.sv
// xlib_ram_sdp: simple dual-port RAM, registered read with enable, no reset
//   clk   : clock
//   we_i  : write enable, wa_i address, wd_i data
//   re_i  : read enable, ra_i address; rd_o updates one edge later and holds otherwise
module xlib_ram_sdp #(
    parameter int AW = 6,
    parameter int W  = 33
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] wa_i,
    input  logic [W-1:0]  wd_i,
    input  logic          re_i,
    input  logic [AW-1:0] ra_i,
    output logic [W-1:0]  rd_o
);
    logic [W-1:0] mem_q [2**AW];
    always_ff @(posedge clk) begin
        if (we_i) mem_q[wa_i] <= wd_i;
        if (re_i) rd_o <= mem_q[ra_i];
    end
endmodule

// File: rtl/xlib_dma_rd_fifo.sv
// xlib_dma_rd_fifo: show-ahead read-data fifo between DMA read engine and a stream sink
//   clk, rst (async, active-high), clr (sync flush)
//   wr_val/wr_dat/wr_eof : write side from the bus read response
//   cnt                  : occupancy (memory words + output register)
//   rd_val/rd_dat/rd_sop/rd_eop/rd_rdy : valid/ready stream output
//   ovf                  : sticky overflow (word dropped while full)
module xlib_dma_rd_fifo
    import xlib_dma_pkg::*;
#(
    parameter int DW = DMA_DW,
    parameter int FW = DMA_FW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr_val,
    input  logic [DW-1:0] wr_dat,
    input  logic          wr_eof,
    output logic [FW:0]   cnt,
    output logic          rd_val,
    output logic [DW-1:0] rd_dat,
    output logic          rd_sop,
    output logic          rd_eop,
    input  logic          rd_rdy,
    output logic          ovf
);
    localparam int TW = tag_w(DW);
    localparam logic [FW:0] CAP = {1'b1, {FW{1'b0}}};
    localparam logic [FW:0] ONE = {{FW{1'b0}}, 1'b1};

    logic          push, pop, ren;
    logic [FW:0]   wptr_q, wptr_d, rptr_q, rptr_d, cnt_q, cnt_d, mcnt;
    logic          val_q, val_d, sop_q, sop_d, ovf_q, ovf_d;
    logic [TW-1:0] q;

    // The RAM read register doubles as the show-ahead output register,
    // so a refill is just a RAM read issued whenever that slot frees up.
    always_comb begin
        pop    = val_q & rd_rdy;
        push   = wr_val & ((cnt_q != CAP) | pop);
        mcnt   = cnt_q - {{FW{1'b0}}, val_q};
        ren    = (mcnt != '0) & (~val_q | pop) & ~clr;
        wptr_d = clr ? '0 : wptr_q + {{FW{1'b0}}, push};
        rptr_d = clr ? '0 : rptr_q + {{FW{1'b0}}, ren};
        cnt_d  = clr ? '0 : (push & ~pop) ? cnt_q + ONE : (pop & ~push) ? cnt_q - ONE : cnt_q;
        val_d  = clr ? 1'b0 : ren | (val_q & ~pop);
        sop_d  = clr ? 1'b1 : pop ? q[DW] : sop_q;
        ovf_d  = clr ? 1'b0 : ovf_q | (wr_val & ~push);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            val_q  <= 1'b0;
            sop_q  <= 1'b1;
            ovf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            val_q  <= val_d;
            sop_q  <= sop_d;
            ovf_q  <= ovf_d;
        end
    end

    // With cnt capped at capacity, a concurrent write and refill never hit the same address.
    xlib_ram_sdp #(.AW(FW), .W(TW)) u_ram (
        .clk  (clk),
        .we_i (push & ~clr),
        .wa_i (wptr_q[FW-1:0]),
        .wd_i ({wr_eof, wr_dat}),
        .re_i (ren),
        .ra_i (rptr_q[FW-1:0]),
        .rd_o (q)
    );

    assign cnt    = cnt_q;
    assign rd_val = val_q;
    assign rd_dat = q[DW-1:0];
    assign rd_eop = val_q & q[DW];
    assign rd_sop = val_q & sop_q;
    assign ovf    = ovf_q;
endmodule

// File: tb/tb_xlib_dma_rd_fifo.sv
// tb_xlib_dma_rd_fifo: table vectors plus scoreboard-checked sequences for xlib_dma_rd_fifo
module tb_xlib_dma_rd_fifo;
    localparam int CAP = 64;

    logic        clk = 1'b0, rst = 1'b1, clr = 1'b0;
    logic        wr_val = 1'b0, wr_eof = 1'b0, rd_rdy = 1'b0;
    logic [31:0] wr_dat = '0;
    logic [6:0]  cnt;
    logic        rd_val, rd_sop, rd_eop, ovf;
    logic [31:0] rd_dat;

    xlib_dma_rd_fifo #(.DW(32), .FW(6)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .wr_val(wr_val), .wr_dat(wr_dat), .wr_eof(wr_eof),
        .cnt(cnt), .rd_val(rd_val), .rd_dat(rd_dat),
        .rd_sop(rd_sop), .rd_eop(rd_eop), .rd_rdy(rd_rdy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // scoreboard model, evaluated between edges while inputs are stable
    logic [32:0] sb[$];
    logic [32:0] e;
    int          m_cnt = 0, cyc = 0, npop = 0, first_pop = 0, last_pop = 0;
    logic        m_ovf = 1'b0, m_sop = 1'b1, stall = 1'b0, mpop, macc;
    logic [31:0] h_dat;
    logic        h_sop, h_eop;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            sb.delete();
            m_cnt = 0;
            m_ovf = 1'b0;
            m_sop = 1'b1;
            stall = 1'b0;
        end else begin
            chkw("cnt", 64'(cnt), 64'(m_cnt));
            chk1("ovf", ovf, m_ovf);
            if (stall) begin
                chk1("hold_val", rd_val, 1'b1);
                chkw("hold_dat", 64'(rd_dat), 64'(h_dat));
                chk1("hold_sop", rd_sop, h_sop);
                chk1("hold_eop", rd_eop, h_eop);
            end
            stall = rd_val && !rd_rdy && !clr;
            h_dat = rd_dat;
            h_sop = rd_sop;
            h_eop = rd_eop;
            if (clr) begin
                sb.delete();
                m_cnt = 0;
                m_ovf = 1'b0;
                m_sop = 1'b1;
            end else begin
                mpop = rd_val && rd_rdy;
                macc = wr_val && (m_cnt < CAP || mpop);
                if (mpop) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_underrun: got word %0h expected none at %0t", rd_dat, $time);
                    end else begin
                        e = sb.pop_front();
                        chkw("dat", 64'(rd_dat), 64'(e[31:0]));
                        chk1("eop", rd_eop, e[32]);
                        chk1("sop", rd_sop, m_sop);
                        m_sop = e[32];
                    end
                    npop++;
                    if (npop == 1) first_pop = cyc;
                    last_pop = cyc;
                end
                if (macc) sb.push_back({wr_eof, wr_dat});
                else if (wr_val) m_ovf = 1'b1;
                m_cnt = m_cnt + int'(macc) - int'(mpop);
            end
        end
    end

    typedef struct {
        logic        wv;
        logic [31:0] wd;
        logic        we;
        logic        rr;
        logic        cl;
        int          ecnt;
        logic        eval, esop, eeop, eovf;
        logic [31:0] edat;
    } vec_t;
    vec_t tv[13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wv, input logic [31:0] wd, input logic we, input logic rr, input logic cl);
        wr_val = wv;
        wr_dat = wd;
        wr_eof = we;
        rd_rdy = rr;
        clr    = cl;
    endtask

    task automatic drain(input string nm);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 300 && cnt != 0; k++) step();
        step();
        chkw(nm, 64'(cnt), 64'(0));
        chk1({nm, "_val"}, rd_val, 1'b0);
        chkw({nm, "_sb"}, 64'(sb.size()), 64'(0));
    endtask

    initial begin
        tv[0]  = '{1'b1, 32'hA1, 1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tv[1]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b1, 1'b0, 32'hA1};
        tv[2]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tv[3]  = '{1'b1, 32'hB2, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tv[4]  = '{1'b1, 32'hB3, 1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b0, 32'hB2};
        tv[5]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b0, 32'hB2};
        tv[6]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b1, 1'b0, 32'hB3};
        tv[7]  = '{1'b1, 32'hC4, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tv[8]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hC4};
        tv[9]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tv[10] = '{1'b1, 32'hD5, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tv[11] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hD5};
        tv[12] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};

        repeat (2) step();
        chkw("rst_cnt", 64'(cnt), 64'(0));
        chk1("rst_val", rd_val, 1'b0);
        chk1("rst_sop", rd_sop, 1'b0);
        chk1("rst_eop", rd_eop, 1'b0);
        chk1("rst_ovf", ovf, 1'b0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 13; i++) begin
            drive(tv[i].wv, tv[i].wd, tv[i].we, tv[i].rr, tv[i].cl);
            step();
            chkw($sformatf("tv%0d_cnt", i), 64'(cnt), 64'(tv[i].ecnt));
            chk1($sformatf("tv%0d_val", i), rd_val, tv[i].eval);
            chk1($sformatf("tv%0d_ovf", i), ovf, tv[i].eovf);
            if (tv[i].eval) begin
                chk1($sformatf("tv%0d_sop", i), rd_sop, tv[i].esop);
                chk1($sformatf("tv%0d_eop", i), rd_eop, tv[i].eeop);
                chkw($sformatf("tv%0d_dat", i), 64'(rd_dat), 64'(tv[i].edat));
            end
        end

        // 200-word stream across pointer wrap, eof every 16th word
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
        step();
        npop = 0;
        for (int i = 1; i <= 200; i++) begin
            drive(1'b1, 32'(i), (i % 16) == 0, 1'b1, 1'b0);
            step();
        end
        drain("stream_drain");
        chkw("stream_pops", 64'(npop), 64'(200));
        chkw("stream_span", 64'(last_pop - first_pop), 64'(199));

        // fill to capacity, push+pop while full, then overflow
        for (int i = 0; i < CAP; i++) begin
            drive(1'b1, 32'(1000 + i), 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step();
        chkw("full_cnt", 64'(cnt), 64'(64));
        chk1("full_ovf", ovf, 1'b0);
        drive(1'b1, 32'h5555, 1'b1, 1'b1, 1'b0);
        step();
        chkw("full_pp_cnt", 64'(cnt), 64'(64));
        chk1("full_pp_ovf", ovf, 1'b0);
        drive(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
        step();
        chkw("ovf_cnt", 64'(cnt), 64'(64));
        chk1("ovf_set", ovf, 1'b1);
        drain("ovf_drain");
        chk1("ovf_sticky", ovf, 1'b1);

        // flush with words queued and ovf set
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'(2000 + i), 1'b0, 1'b0, 1'b0);
            step();
        end
        chkw("preclr_cnt", 64'(cnt), 64'(10));
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step();
        chkw("clr_cnt", 64'(cnt), 64'(0));
        chk1("clr_val", rd_val, 1'b0);
        chk1("clr_ovf", ovf, 1'b0);
        drive(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step();
        chk1("clr_next_val", rd_val, 1'b1);
        chk1("clr_next_sop", rd_sop, 1'b1);
        chkw("clr_next_dat", 64'(rd_dat), 64'(32'h77));
        drain("clr_drain");

        // random traffic with backpressure
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), 1'b0);
            step();
        end
        drain("rand_drain");

        // asynchronous reset in the middle of a transfer
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'(3000 + i), 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chkw("arst_cnt", 64'(cnt), 64'(0));
        chk1("arst_val", rd_val, 1'b0);
        chk1("arst_sop", rd_sop, 1'b0);
        chk1("arst_eop", rd_eop, 1'b0);
        step();
        rst = 1'b0;
        step();
        drive(1'b1, 32'h99, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step();
        chk1("arst_next_val", rd_val, 1'b1);
        chk1("arst_next_sop", rd_sop, 1'b1);
        chkw("arst_next_dat", 64'(rd_dat), 64'(32'h99));
        drain("arst_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish by 500000");
        $fatal(1);
    end
endmodule

// File: doc/xlib_dma_rd_fifo.md
XLIB_DMA_RD_FIFO -- requirements
Module: xlib_dma_rd_fifo

Interface
REQ-001 Parameter DW, default 32, data width in bits.
REQ-002 Parameter FW, default 6, fifo level width; capacity 2**FW words.
REQ-003 clk  input  1  single clock, all logic rising-edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 clr  input  1  synchronous flush, active-high.
REQ-006 wr_val  input  1  write strobe; the DMA read engine's rsp_val/dff_ack drives this pin.
REQ-007 wr_dat  input  DW  write data, the bus read data.
REQ-008 wr_eof  input  1  last-word tag; the DMA read engine's dff_eof drives this pin.
REQ-009 cnt  output  FW+1  occupancy; feeds the DMA read engine's dff_cnt.
REQ-010 rd_val  output  1  stream valid.
REQ-011 rd_dat  output  DW  stream data.
REQ-012 rd_sop  output  1  first word of a transfer.
REQ-013 rd_eop  output  1  last word of a transfer (stored wr_eof).
REQ-014 rd_rdy  input  1  stream ready from sink.
REQ-015 ovf  output  1  sticky overflow error.

Function
REQ-016 Storage: 2**FW x (DW+1) memory (data plus eof tag), write and read pointers FW+1 bits wide, plus a show-ahead output register.
REQ-017 Push = wr_val & (cnt<2**FW | pop); pop = rd_val & rd_rdy.
REQ-018 cnt = words in memory + output register occupancy; updates at the edge of push/pop: +1 push only, -1 pop only, unchanged when both or neither.
REQ-019 cnt never exceeds 2**FW and never wraps below 0.
REQ-020 Latency: a word pushed into an empty fifo at edge N gives rd_val=1 after edge N+1, with its data and eop on rd_dat/rd_eop.
REQ-021 Output register: refills from memory at the same edge as a pop when memory is non-empty.
REQ-022 Back-to-back: sustained push and pop at one word per cycle, no bubbles.
REQ-023 rd_dat, rd_eop, rd_sop: held stable while rd_val=1 and rd_rdy=0.
REQ-024 rd_sop: 1 on the first word after reset or clr, and on the first word after a popped word with rd_eop=1; 0 otherwise.
REQ-025 Overflow: wr_val while cnt==2**FW and no pop -> word dropped, ovf set at next edge, cnt unchanged.
REQ-026 ovf: stays set until rst or clr.
REQ-027 Underflow: rd_rdy with rd_val=0 has no effect.
REQ-028 Pointer wrap-around: modulo 2**FW on the address bits; full/empty come from cnt, not pointer compare.
REQ-029 clr: at the next edge, pointers=0, cnt=0, rd_val=0, sop state=armed, ovf=0; a push or pop in the clr cycle is discarded.

Reset
REQ-030 On rst assertion, immediately (asynchronously): pointers=0, cnt=0, rd_val=0, rd_sop=0, rd_eop=0, ovf=0, sop state=armed.
REQ-031 rd_dat after reset: don't-care while rd_val=0.
REQ-032 Memory contents are not reset.
REQ-033 rst deassertion mid-transfer: the fifo resumes empty, and the first subsequent word has rd_sop=1.

Structure
REQ-034 Shared package xlib_dma_pkg holds the default DW and FW constants and the tagged-word width DW+1.
REQ-035 One sub-module, xlib_ram_sdp: a simple dual-port RAM with registered read, no reset.
REQ-036 Counter, pointers, output register and sop/ovf flags live in xlib_dma_rd_fifo.

Verification
REQ-037 Reset, then push 0xA1 with eof=1 while rd_rdy=1 -> cnt=1 after the push edge; rd_val, rd_sop and rd_eop all 1 one cycle later; cnt=0 after the pop.
REQ-038 FW=6, rd_rdy=0, push 64 words -> cnt=64; push a 65th -> dropped, ovf=1, cnt=64; then drain -> 64 words in order, the 65th absent.
REQ-039 Full fifo with simultaneous push and pop -> push accepted, cnt stays 64, ovf stays 0.
REQ-040 Continuous 200-word stream with eof on words 16/32/..., rd_rdy=1 -> no bubbles, data in order across pointer wrap, rd_sop on words 1/17/33/..., rd_eop on words 16/32/....
REQ-041 Random rd_rdy backpressure -> rd_dat stable while stalled; scoreboard matches.
REQ-042 clr with 10 words queued and ovf=1 -> next cycle cnt=0, rd_val=0, ovf=0; the next pushed word has rd_sop=1.
